// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a post-reset clear sweep, optional
// write-to-read bypass and a per-register pending (scoreboard) bit.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DEPTH-1:0]    pending_q, pending_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                run;
  logic                wr_valid;
  logic                busy_valid;
  logic                hit_1, hit_2;
  logic                zero_1, zero_2;

  assign run        = (state_q == RUN);
  assign wr_valid   = run && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign busy_valid = run && busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q[ADDR_W-1:0];
        mem_wdata = '0;
        idx_d     = idx_q + {{ADDR_W{1'b0}}, 1'b1};
        if (idx_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_we = wr_valid;
        // Set is applied after clear so a newly issued producer stays pending.
        if (wr_valid) begin
          pending_d[wr_addr] = 1'b0;
        end
        if (busy_valid) begin
          pending_d[busy_addr] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign zero_1 = (ZERO_REG != 0) && (rd_addr_1 == '0);
  assign zero_2 = (ZERO_REG != 0) && (rd_addr_2 == '0);
  assign hit_1  = (BYPASS != 0) && wr_valid && (wr_addr == rd_addr_1);
  assign hit_2  = (BYPASS != 0) && wr_valid && (wr_addr == rd_addr_2);

  assign rd_data_1 = (!run || zero_1) ? '0 : (hit_1 ? wr_data : mem_q[rd_addr_1]);
  assign rd_data_2 = (!run || zero_2) ? '0 : (hit_2 ? wr_data : mem_q[rd_addr_2]);
  assign rd_busy_1 = run && pending_q[rd_addr_1] && !hit_1;
  assign rd_busy_2 = run && pending_q[rd_addr_2] && !hit_2;
  assign ready     = run;

endmodule
